// File: rtl/branch_predictor_bht.sv
// Fetch-stage branch predictor: JAL/B-type immediate decode plus a PC-indexed table of saturating counters.
// Optional BHT_BTFN_FALLBACK_EN adds per-entry valid bits with backward-taken/forward-not-taken fallback.

`ifndef J_JAL
`define J_JAL 7'b1101111
`endif
`ifndef B_TYPE
`define B_TYPE 7'b1100011
`endif

module branch_predictor_bht #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int STAT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic [31:0]          PC,
  output logic [31:0]          PC_predict,
  output logic                 predict_taken,
  input  logic                 update_valid,
  input  logic [31:0]          update_pc,
  input  logic                 update_taken,
  input  logic                 update_mispredict,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;
  localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1);

  logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_d [ENTRIES];
  logic [STAT_BITS-1:0]  stat_branches_q, stat_branches_d;
  logic [STAT_BITS-1:0]  stat_mispredicts_q, stat_mispredicts_d;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [31:0]           uj_imm;
  logic [31:0]           sb_imm;
  logic                  table_taken;
  logic                  unused_update_pc_bits;

  assign lookup_idx = PC[INDEX_BITS+1:2];
  assign update_idx = update_pc[INDEX_BITS+1:2];
  assign unused_update_pc_bits = ^{update_pc[31:INDEX_BITS+2], update_pc[1:0]};

  assign uj_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
  assign sb_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};

`ifdef BHT_BTFN_FALLBACK_EN
  logic [ENTRIES-1:0] valid_q, valid_d;

  // Untrained entries fall back to the static direction heuristic.
  assign table_taken = valid_q[lookup_idx] ? ctr_q[lookup_idx][CTR_BITS-1] : sb_imm[31];

  always_comb begin
    valid_d = valid_q;
    if (update_valid) valid_d[update_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end
`else
  assign table_taken = ctr_q[lookup_idx][CTR_BITS-1];
`endif

  always_comb begin
    PC_predict    = PC + 32'd4;
    predict_taken = 1'b0;
    case (instruction[6:0])
      `J_JAL: begin
        PC_predict    = PC + uj_imm;
        predict_taken = 1'b1;
      end
      `B_TYPE: begin
        if (table_taken) begin
          PC_predict    = PC + sb_imm;
          predict_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counters saturate at both ends; the lookup above always sees the pre-update value.
  always_comb begin
    ctr_d = ctr_q;
    if (update_valid) begin
      if (update_taken) begin
        if (ctr_q[update_idx] != CTR_MAX) ctr_d[update_idx] = ctr_q[update_idx] + CTR_ONE;
      end else begin
        if (ctr_q[update_idx] != '0) ctr_d[update_idx] = ctr_q[update_idx] - CTR_ONE;
      end
    end
  end

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (update_valid) begin
      if (stat_branches_q != STAT_MAX) stat_branches_d = stat_branches_q + STAT_ONE;
      if (update_mispredict && (stat_mispredicts_q != STAT_MAX))
        stat_mispredicts_d = stat_mispredicts_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      ctr_q              <= ctr_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: vector table plus hand-written reset/saturation sequences.
// Expectations adapt to BHT_BTFN_FALLBACK_EN when it is defined.

module tb_branch_predictor_bht;

`ifdef BHT_BTFN_FALLBACK_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic [31:0] PC_predict;
  logic        predict_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor_bht #(.INDEX_BITS(6), .CTR_BITS(2), .STAT_BITS(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .instruction      (instruction),
    .PC               (PC),
    .PC_predict       (PC_predict),
    .predict_taken    (predict_taken),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        um;
    logic [31:0] exp_pc;
    logic        exp_t;
  } vec_t;

  typedef struct {
    logic [31:0] exp_pc;
    logic        exp_t;
    string       name;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[20];
  int   compared   = 0;
  int   mismatched = 0;

  logic [31:0] b_neg16, b_pos8, jal40, nop;

  function automatic logic [31:0] make_b(input logic [12:0] o);
    make_b = {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] make_jal(input logic [20:0] o);
    make_jal = {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic um, input logic [31:0] exp_pc, input logic exp_t);
    mk = '{instr, pc, uv, upc, ut, um, exp_pc, exp_t};
  endfunction

  task automatic applyStimulus(input vec_t v, input string name);
    @(posedge clk); #1;
    reset             = 1'b0;
    instruction       = v.instr;
    PC                = v.pc;
    update_valid      = v.uv;
    update_pc         = v.upc;
    update_taken      = v.ut;
    update_mispredict = v.um;
    sbq.push_back('{v.exp_pc, v.exp_t, name});
  endtask

  task automatic checkOutput();
    sb_t e;
    @(negedge clk);
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard: no expected entry queued");
    end else begin
      e = sbq.pop_front();
      if (PC_predict !== e.exp_pc || predict_taken !== e.exp_t) begin
        mismatched++;
        $display("[TB] FAIL %s: got PC_predict=%h taken=%b, expected %h/%b",
                 e.name, PC_predict, predict_taken, e.exp_pc, e.exp_t);
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    update_valid      = 1'b0;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
    instruction       = nop;
  endtask

  task automatic checkStats(input logic [31:0] eb, input logic [31:0] em, input string name);
    @(negedge clk);
    compared++;
    if (stat_branches !== eb || stat_mispredicts !== em) begin
      mismatched++;
      $display("[TB] FAIL %s: got stats %0d/%0d, expected %0d/%0d",
               name, stat_branches, stat_mispredicts, eb, em);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    b_neg16 = make_b(13'h1FF0);
    b_pos8  = make_b(13'd8);
    jal40   = make_jal(21'h40);
    nop     = 32'h0000_0013;

    // PCs 0x100 and 0x200 alias onto index 0; 0x104 is index 1, 0x108 index 2.
    vecs[0]  = mk(b_neg16, 32'h100, 0, 32'h0,   0, 0, BTFN ? 32'h0F0 : 32'h104, BTFN);
    vecs[1]  = mk(b_pos8,  32'h100, 0, 32'h0,   0, 0, 32'h104, 0);
    vecs[2]  = mk(jal40,   32'h200, 0, 32'h0,   0, 0, 32'h240, 1);
    vecs[3]  = mk(nop,     32'h100, 0, 32'h0,   0, 0, 32'h104, 0);
    vecs[4]  = mk(b_pos8,  32'h100, 1, 32'h100, 1, 1, 32'h104, 0);
    vecs[5]  = mk(b_pos8,  32'h100, 1, 32'h100, 1, 0, 32'h108, 1);
    vecs[6]  = mk(b_pos8,  32'h100, 1, 32'h100, 1, 0, 32'h108, 1);
    vecs[7]  = mk(b_pos8,  32'h100, 1, 32'h100, 0, 1, 32'h108, 1);
    vecs[8]  = mk(b_pos8,  32'h100, 0, 32'h100, 0, 1, 32'h108, 1);
    vecs[9]  = mk(b_pos8,  32'h200, 0, 32'h0,   0, 0, 32'h208, 1);
    vecs[10] = mk(jal40,   32'h200, 0, 32'h0,   0, 0, 32'h240, 1);
    vecs[11] = mk(b_pos8,  32'h100, 1, 32'h100, 0, 0, 32'h108, 1);
    vecs[12] = mk(b_pos8,  32'h100, 1, 32'h100, 0, 1, 32'h104, 0);
    vecs[13] = mk(b_pos8,  32'h100, 1, 32'h100, 0, 0, 32'h104, 0);
    vecs[14] = mk(b_neg16, 32'h100, 0, 32'h0,   0, 0, 32'h104, 0);
    vecs[15] = mk(b_pos8,  32'h104, 1, 32'h104, 1, 0, 32'h108, 0);
    vecs[16] = mk(b_pos8,  32'h104, 0, 32'h0,   0, 0, 32'h10C, 1);
    vecs[17] = mk(b_pos8,  32'h108, 1, 32'h108, 0, 0, 32'h10C, 0);
    vecs[18] = mk(b_pos8,  32'h108, 1, 32'h108, 0, 0, 32'h10C, 0);
    vecs[19] = mk(b_pos8,  32'h108, 0, 32'h0,   0, 0, 32'h10C, 0);

    reset = 1'b1; instruction = nop; PC = 32'h0; update_valid = 1'b0;
    update_pc = 32'h0; update_taken = 1'b0; update_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkStats(32'd0, 32'd0, "stats_after_reset");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput();
    end
    idle();
    checkStats(32'd10, 32'd3, "stats_before_reset");

    // Reset asserted together with a taken update on index 1 (counter at 2); update must be lost.
    @(posedge clk); #1;
    reset = 1'b1; update_valid = 1'b1; update_pc = 32'h104;
    update_taken = 1'b1; update_mispredict = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; update_valid = 1'b0; update_taken = 1'b0; update_mispredict = 1'b0;
    checkStats(32'd0, 32'd0, "stats_after_midstream_reset");

    applyStimulus(mk(b_neg16, 32'h100, 0, 32'h0, 0, 0, BTFN ? 32'h0F0 : 32'h104, BTFN), "post_reset_backward");
    checkOutput();
    applyStimulus(mk(b_pos8, 32'h104, 0, 32'h0, 0, 0, 32'h108, 0), "post_reset_update_lost");
    checkOutput();
    applyStimulus(mk(jal40, 32'h200, 0, 32'h0, 0, 0, 32'h240, 1), "post_reset_jal");
    checkOutput();

    for (int i = 0; i < 64; i++) begin
      applyStimulus(mk(b_pos8, 32'(i * 4), 0, 32'h0, 0, 0, 32'(i * 4 + 4), 0),
                    $sformatf("post_reset_idx%0d", i));
      checkOutput();
    end

    applyStimulus(mk(b_pos8, 32'h10, 1, 32'h10, 1, 0, 32'h14, 0), "weak_nt_same_cycle");
    checkOutput();
    applyStimulus(mk(b_pos8, 32'h10, 0, 32'h0, 0, 0, 32'h18, 1), "weak_nt_one_step");
    checkOutput();
    idle();
    checkStats(32'd1, 32'd0, "stats_after_one_update");

    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
